// File: rtl/regfile_pkg.sv
// Shared constants and the write-port record for the multi-port register file.
package regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]  data;
        logic [DEF_ADDR_W-1:0] addr;
        logic                  en;
    } wr_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for in-flight results, plus a registered popcount.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] clr0_addr,
    input  logic              clr0_en,
    input  logic [ADDR_W-1:0] clr1_addr,
    input  logic              clr1_en,
    output logic [DEPTH-1:0]  pending,
    output logic [ADDR_W:0]   count
);

    logic [DEPTH-1:0] pend_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             issue_ok;

    assign issue_ok = issue_en &&
        !(ZERO_REG && issue_addr == ADDR_W'(ZERO_ADDR));

    // Issue is applied last: a new producer outranks a retiring one.
    always_comb begin
        pend_nxt = pending;
        if (clr0_en) pend_nxt[clr0_addr] = 1'b0;
        if (clr1_en) pend_nxt[clr1_addr] = 1'b0;
        if (issue_ok) pend_nxt[issue_addr] = 1'b1;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            count   <= '0;
        end else begin
            pending <= pend_nxt;
            count   <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD read ports, two write ports,
// optional bypass and hardwired zero register, pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     Clk,
    input  logic                     nReset,
    input  logic [WIDTH-1:0]         WriteData0,
    input  logic [ADDR_W-1:0]        WriteRegister0,
    input  logic                     wEnable0,
    input  logic [WIDTH-1:0]         WriteData1,
    input  logic [ADDR_W-1:0]        WriteRegister1,
    input  logic                     wEnable1,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*WIDTH-1:0]  ReadData,
    output logic [NUM_RD-1:0]        ReadPending,
    input  logic [ADDR_W-1:0]        IssueRegister,
    input  logic                     IssueEnable,
    output logic                     WriteCollision,
    output logic [ADDR_W:0]          PendingCount
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             we0, we1;
    logic             fwd0, fwd1;

    assign we0 = wEnable0 &&
        !(ZERO_REG && WriteRegister0 == ADDR_W'(ZERO_ADDR));
    assign we1 = wEnable1 &&
        !(ZERO_REG && WriteRegister1 == ADDR_W'(ZERO_ADDR));

    // Forwarding is suppressed in reset so every read port shows zero.
    assign fwd0 = BYPASS && we0 && nReset;
    assign fwd1 = BYPASS && we1 && nReset;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            WriteCollision <= 1'b0;
        end else begin
            if (we0) mem[WriteRegister0] <= WriteData0;
            if (we1) mem[WriteRegister1] <= WriteData1;
            WriteCollision <= we0 && we1 &&
                (WriteRegister0 == WriteRegister1);
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              is_zero;
        logic              hit0, hit1;

        assign ra      = ReadRegister[i*ADDR_W +: ADDR_W];
        assign is_zero = ZERO_REG && ra == ADDR_W'(ZERO_ADDR);
        assign hit0    = fwd0 && WriteRegister0 == ra;
        assign hit1    = fwd1 && WriteRegister1 == ra;

        assign ReadData[i*WIDTH +: WIDTH] =
            is_zero ? '0 :
            hit1    ? WriteData1 :
            hit0    ? WriteData0 :
                      mem[ra];

        assign ReadPending[i] = pending[ra] && !(hit0 || hit1);
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (Clk),
        .rst_n      (nReset),
        .issue_addr (IssueRegister),
        .issue_en   (IssueEnable),
        .clr0_addr  (WriteRegister0),
        .clr0_en    (we0),
        .clr1_addr  (WriteRegister1),
        .clr1_en    (we1),
        .pending    (pending),
        .count      (PendingCount)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: bypassing and non-bypassing instances.
module tb_regfile_mp;

    logic        Clk = 1'b0;
    logic        nReset;
    logic [31:0] WriteData0, WriteData1;
    logic [4:0]  WriteRegister0, WriteRegister1;
    logic        wEnable0, wEnable1;
    logic [9:0]  ReadRegister;
    logic [4:0]  IssueRegister;
    logic        IssueEnable;

    logic [63:0] rd_b, rd_n;
    logic [1:0]  rp_b, rp_n;
    logic        col_b, col_n;
    logic [5:0]  cnt_b, cnt_n;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    regfile_mp #(.BYPASS(1'b1)) dut (
        .Clk(Clk), .nReset(nReset),
        .WriteData0(WriteData0), .WriteRegister0(WriteRegister0),
        .wEnable0(wEnable0),
        .WriteData1(WriteData1), .WriteRegister1(WriteRegister1),
        .wEnable1(wEnable1),
        .ReadRegister(ReadRegister), .ReadData(rd_b),
        .ReadPending(rp_b),
        .IssueRegister(IssueRegister), .IssueEnable(IssueEnable),
        .WriteCollision(col_b), .PendingCount(cnt_b)
    );

    regfile_mp #(.BYPASS(1'b0)) dut_nb (
        .Clk(Clk), .nReset(nReset),
        .WriteData0(WriteData0), .WriteRegister0(WriteRegister0),
        .wEnable0(wEnable0),
        .WriteData1(WriteData1), .WriteRegister1(WriteRegister1),
        .wEnable1(wEnable1),
        .ReadRegister(ReadRegister), .ReadData(rd_n),
        .ReadPending(rp_n),
        .IssueRegister(IssueRegister), .IssueEnable(IssueEnable),
        .WriteCollision(col_n), .PendingCount(cnt_n)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        wEnable0 = 0; wEnable1 = 0; IssueEnable = 0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        ReadRegister = {a1, a0};
        #1;
    endtask

    task automatic test_reset();
        nReset = 0; idle();
        WriteData0 = 0; WriteData1 = 0;
        WriteRegister0 = 0; WriteRegister1 = 0; IssueRegister = 0;
        tick(); tick();
        rd(5, 31);
        total++; if (rd_b[31:0] !== 32'd0) begin bad++; $display("FAIL rst_rd5 got %0d want 0", rd_b[31:0]); end
        total++; if (rd_b[63:32] !== 32'd0) begin bad++; $display("FAIL rst_rd31 got %0d want 0", rd_b[63:32]); end
        total++; if (cnt_b !== 6'd0 || col_b !== 1'b0) begin bad++; $display("FAIL rst_flags got cnt=%0d col=%0b want 0/0", cnt_b, col_b); end
        nReset = 1;
        tick();
        wEnable0 = 1; WriteRegister0 = 7; WriteData0 = 42;
        IssueEnable = 1; IssueRegister = 20;
        tick(); idle();
        rd(7, 7);
        total++; if (rd_b[31:0] !== 32'd42) begin bad++; $display("FAIL pre_rst_rd7 got %0d want 42", rd_b[31:0]); end
        total++; if (cnt_b !== 6'd1) begin bad++; $display("FAIL pre_rst_cnt got %0d want 1", cnt_b); end
        nReset = 0;
        #1;
        total++; if (rd_b[31:0] !== 32'd0 || rd_n[63:32] !== 32'd0) begin bad++; $display("FAIL mid_rst_rd7 got %0d/%0d want 0", rd_b[31:0], rd_n[63:32]); end
        total++; if (cnt_b !== 6'd0) begin bad++; $display("FAIL mid_rst_cnt got %0d want 0", cnt_b); end
        tick();
        nReset = 1;
        tick();
    endtask

    task automatic test_dual_write();
        wEnable0 = 1; WriteRegister0 = 2; WriteData0 = 42;
        wEnable1 = 1; WriteRegister1 = 11; WriteData1 = 40;
        tick(); idle();
        rd(2, 11);
        total++; if (rd_n[31:0] !== 32'd42) begin bad++; $display("FAIL dw_r2 got %0d want 42", rd_n[31:0]); end
        total++; if (rd_n[63:32] !== 32'd40) begin bad++; $display("FAIL dw_r11 got %0d want 40", rd_n[63:32]); end
        total++; if (col_b !== 1'b0) begin bad++; $display("FAIL dw_col got %0b want 0", col_b); end
        WriteData0 = 12; WriteData1 = 12;
        tick();
        total++; if (rd_b[31:0] !== 32'd42 || rd_b[63:32] !== 32'd40) begin bad++; $display("FAIL dw_hold got %0d/%0d want 42/40", rd_b[31:0], rd_b[63:32]); end
    endtask

    task automatic test_collision();
        wEnable0 = 1; WriteRegister0 = 12; WriteData0 = 15;
        wEnable1 = 1; WriteRegister1 = 12; WriteData1 = 99;
        rd(12, 12);
        total++; if (rd_b[31:0] !== 32'd99) begin bad++; $display("FAIL col_byp got %0d want 99", rd_b[31:0]); end
        tick(); idle();
        rd(12, 12);
        total++; if (rd_n[31:0] !== 32'd99) begin bad++; $display("FAIL col_r12 got %0d want 99", rd_n[31:0]); end
        total++; if (col_b !== 1'b1 || col_n !== 1'b1) begin bad++; $display("FAIL col_set got %0b/%0b want 1", col_b, col_n); end
        tick();
        total++; if (col_b !== 1'b0) begin bad++; $display("FAIL col_clr got %0b want 0", col_b); end
    endtask

    task automatic test_zero();
        wEnable0 = 1; WriteRegister0 = 0; WriteData0 = 42;
        wEnable1 = 1; WriteRegister1 = 0; WriteData1 = 42;
        rd(0, 0);
        total++; if (rd_b !== 64'd0) begin bad++; $display("FAIL z_byp got %0h want 0", rd_b); end
        tick(); idle();
        rd(0, 0);
        total++; if (rd_n !== 64'd0) begin bad++; $display("FAIL z_rd got %0h want 0", rd_n); end
        total++; if (col_b !== 1'b0) begin bad++; $display("FAIL z_col got %0b want 0", col_b); end
        IssueEnable = 1; IssueRegister = 0;
        tick(); idle();
        total++; if (cnt_b !== 6'd0 || rp_b !== 2'b00) begin bad++; $display("FAIL z_issue got cnt=%0d rp=%0b want 0/0", cnt_b, rp_b); end
    endtask

    task automatic test_bypass();
        wEnable0 = 1; WriteRegister0 = 3; WriteData0 = 7;
        tick();
        WriteData0 = 55;
        rd(3, 3);
        total++; if (rd_b[31:0] !== 32'd55) begin bad++; $display("FAIL byp_on got %0d want 55", rd_b[31:0]); end
        total++; if (rd_n[31:0] !== 32'd7) begin bad++; $display("FAIL byp_off_pre got %0d want 7", rd_n[31:0]); end
        tick(); idle();
        #1;
        total++; if (rd_n[63:32] !== 32'd55) begin bad++; $display("FAIL byp_off_post got %0d want 55", rd_n[63:32]); end
    endtask

    task automatic test_scoreboard();
        IssueEnable = 1; IssueRegister = 4;
        tick();
        IssueRegister = 9;
        tick(); idle();
        rd(4, 9);
        total++; if (cnt_b !== 6'd2) begin bad++; $display("FAIL sb_cnt2 got %0d want 2", cnt_b); end
        total++; if (rp_b !== 2'b11) begin bad++; $display("FAIL sb_rp got %0b want 11", rp_b); end
        wEnable1 = 1; WriteRegister1 = 4; WriteData1 = 3;
        #1;
        total++; if (rp_b !== 2'b10 || rp_n !== 2'b11) begin bad++; $display("FAIL sb_rp_fwd got %0b/%0b want 10/11", rp_b, rp_n); end
        IssueEnable = 1; IssueRegister = 4;
        tick(); idle();
        #1;
        total++; if (rp_b[0] !== 1'b1 || cnt_b !== 6'd2) begin bad++; $display("FAIL sb_issue_wins got rp=%0b cnt=%0d want 1/2", rp_b[0], cnt_b); end
        wEnable0 = 1; WriteRegister0 = 9; WriteData0 = 1;
        tick(); idle();
        #1;
        total++; if (cnt_b !== 6'd1 || rp_b[1] !== 1'b0) begin bad++; $display("FAIL sb_clr9 got cnt=%0d rp=%0b want 1/0", cnt_b, rp_b[1]); end
        wEnable0 = 1; WriteRegister0 = 4;
        tick(); idle();
        #1;
        total++; if (cnt_b !== 6'd0 || cnt_n !== 6'd0) begin bad++; $display("FAIL sb_clr4 got %0d/%0d want 0", cnt_b, cnt_n); end
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_collision();
        test_zero();
        test_bypass();
        test_scoreboard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file: successor to the 32x32 two-read / one-write register file.
- Width, depth and read-port count are generalised.
- Adds a second write port with defined collision priority, optional write-to-read bypass, optional hardwired zero register, and a per-register pending scoreboard for in-flight results.
- Sits in the CPU datapath between decode (read/issue) and writeback (two result buses).

Parameters:
- WIDTH, 32: data word width in bits.
- DEPTH, 32: number of registers; power of two, at least 4.
- ADDR_W, 5: address width; must equal log2(DEPTH).
- NUM_RD, 2: number of read ports, 1 to 4.
- ZERO_REG, 1: 1 means register 0 reads 0, ignores writes and is never pending.
- BYPASS, 1: 1 means read data forwards same-cycle write data.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- nReset  in  1  asynchronous, active-low reset.
- WriteData0  in  WIDTH  write port 0 data.
- WriteRegister0  in  ADDR_W  write port 0 address.
- wEnable0  in  1  write port 0 enable.
- WriteData1  in  WIDTH  write port 1 data.
- WriteRegister1  in  ADDR_W  write port 1 address.
- wEnable1  in  1  write port 1 enable.
- ReadRegister  in  NUM_RD*ADDR_W  packed read addresses; port i at bits [i*ADDR_W +: ADDR_W].
- ReadData  out  NUM_RD*WIDTH  packed read data; port i at bits [i*WIDTH +: WIDTH].
- ReadPending  out  NUM_RD  pending flag of each read port's addressed register.
- IssueRegister  in  ADDR_W  destination register being issued.
- IssueEnable  in  1  marks IssueRegister pending.
- WriteCollision  out  1  registered; 1 for one cycle after both ports wrote the same address.
- PendingCount  out  ADDR_W+1  registered population count of pending bits.

Behaviour:
- Reset: while nReset is low, asynchronously clear all registers, all pending bits, WriteCollision and PendingCount to 0. Every ReadData reads 0. Reset asserted mid-operation discards any write on that edge.
- Write: on the rising edge, reg[WriteRegisterN] <= WriteDataN when wEnableN is 1.
- Write collision: when both ports are enabled to the same address, port 1 wins. WriteCollision is 1 on the following cycle only. A collision on register 0 with ZERO_REG=1 does not set WriteCollision.
- ZERO_REG=1: writes to register 0 are dropped; reads of register 0 return 0; issues to register 0 are ignored.
- Read: combinational, no clock needed; ReadData follows ReadRegister within the same cycle.
- BYPASS=1: if a read address equals an enabled write address (and is not register 0 with ZERO_REG=1), ReadData returns that write data, port 1 over port 0.
- BYPASS=0: ReadData returns the stored value; the new value is visible after the edge.
- Scoreboard: pending[a] is set on the edge where IssueEnable=1 and IssueRegister=a. It is cleared on the edge where any enabled write targets a. Simultaneous issue and write to the same address leaves it set (issue wins, new producer).
- ReadPending[i] = pending[addr_i] AND NOT (BYPASS=1 AND an enabled write hits addr_i this cycle).
- PendingCount reflects the pending bits after each edge; it runs 0 to DEPTH (DEPTH-1 with ZERO_REG=1). No wrap is possible.
- Undriven or X inputs are outside the contract; no X-suppression is required.

Decomposition:
- Shared package regfile_pkg holds:
  - the default WIDTH, DEPTH and ADDR_W constants;
  - the ZERO_ADDR constant (0);
  - a write-port record typedef (data, address, enable) reused by writeback.
- One sub-module, regfile_scoreboard, holds the pending bit vector, the issue/clear priority and the PendingCount popcount.
- The storage array, write logic and per-port read/bypass muxes stay in regfile_mp, with one generate loop over NUM_RD.

Test Plan:
- Reset, then read registers 5 and 31 on both ports -> 0 and 0. Assert nReset low mid-test after writing 42 to register 7 -> register 7 reads 0 immediately.
- wEnable0 writes 42 to register 2, wEnable1 writes 40 to register 11 in the same cycle. Read port 0 at 2, port 1 at 11 -> 42 and 40. Repeat with the enables low and data 12 -> values unchanged.
- Both ports write register 12, port 0 data 15, port 1 data 99 -> register 12 = 99; WriteCollision = 1 for exactly one cycle, then 0.
- Write 42 to register 0 on both ports -> reads 0 and WriteCollision = 0. Issue register 0 -> PendingCount stays 0.
- BYPASS=1: register 3 holds 7; wEnable0 with data 55 to register 3 while reading register 3 -> ReadData shows 55 before the edge. BYPASS=0 -> shows 7 before the edge and 55 after.
- Issue registers 4 and 9 -> PendingCount = 2 and ReadPending high at 4. Issue 4 and write 4 on the same edge -> still pending. Write 9 -> PendingCount = 1.
